// File: rtl/instr_encoder_loader.sv
// Packs R/I/S field sets into RV32I words and streams them into instruction memory.
// One-cycle write latency after acceptance; in_ready is high only in LOAD.
module instr_encoder_loader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [1:0]    fmt,
  input  logic [6:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [11:0]   imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count,
  output logic          err_fmt,
  output logic          err_full
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [AW:0]   wc_inc;
  logic [31:0]   enc;
  logic          legal, accept, full;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign accept   = in_valid & in_ready;
  assign wc_inc   = word_count + (AW+1)'(1);
  assign full     = (wc_inc == FULL_CNT);

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (fmt)
      2'b00: begin
        enc   = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = (opcode == 7'b0110011);
      end
      2'b01: begin
        enc   = {imm, rs1, funct3, rd, opcode};
        legal = (opcode == 7'b0010011) || (opcode == 7'b0000011);
      end
      2'b10: begin
        enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = (opcode == 7'b0100011);
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      // A bad beat with in_last still ends the session; only good beats can fill memory
      LOAD:    if (accept && (in_last || (legal && full))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      err_fmt    <= 1'b0;
      err_full   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (state == IDLE && start) begin
        ptr        <= base_addr;
        word_count <= '0;
        err_fmt    <= 1'b0;
        err_full   <= 1'b0;
      end
      if (accept) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= enc;
          ptr        <= ptr + AW'(1);
          word_count <= wc_inc;
          if (full && !in_last) err_full <= 1'b1;
        end else begin
          err_fmt <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: table of encoded vectors plus hand sequences;
// writes are checked against a queue of expected {addr, word} pairs.
module tb_instr_encoder_loader;

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic        last;
    logic        good;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [7:0]  base_addr;
  logic [1:0]  fmt;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] imm;

  logic        in_ready, imem_we, busy, done, err_fmt, err_full;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        in_ready2, imem_we2, busy2, done2, err_fmt2, err_full2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  word_count2;

  int          n_pass = 0, n_total = 0;
  logic [39:0] q[$];
  logic [39:0] q2[$];
  logic [7:0]  eptr;
  logic [1:0]  eptr2;
  logic        en2 = 1'b0;
  vec_t        vt[10];

  always #5 clk = ~clk;

  instr_encoder_loader #(.AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .word_count(word_count),
    .err_fmt(err_fmt), .err_full(err_full)
  );

  instr_encoder_loader #(.AW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr[1:0]),
    .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .word_count(word_count2),
    .err_fmt(err_fmt2), .err_full(err_full2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] f, input logic [6:0] op,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] im,
                              input logic last, input logic good, input logic [31:0] w);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.f3 = f3; v.f7 = f7; v.imm = im; v.last = last; v.good = good; v.word = w;
    return v;
  endfunction

  always @(negedge clk) begin
    if (imem_we) begin
      if (q.size() == 0) chk("unexpected_write", 64'(imem_we), 64'd0);
      else chk("write_addr_data", 64'({imem_addr, imem_wdata}), 64'(q.pop_front()));
    end
    if (en2 && imem_we2) begin
      if (q2.size() == 0) chk("unexpected_write_aw2", 64'(imem_we2), 64'd0);
      else chk("write_addr_data_aw2", 64'({6'b0, imem_addr2, imem_wdata2}), 64'(q2.pop_front()));
    end
  end

  task automatic drive_fields(input vec_t v, input logic last);
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    in_valid = 1'b1; in_last = last;
  endtask

  task automatic send(input vec_t v, input logic last);
    int k = 0;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    drive_fields(v, last);
    if (v.good) begin
      q.push_back({eptr, v.word});
      eptr = eptr + 8'd1;
      if (en2) begin
        q2.push_back({6'b0, eptr2, v.word});
        eptr2 = eptr2 + 2'd1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] b);
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    eptr = b; eptr2 = b[1:0];
    chk("start_busy_ready", 64'({busy, in_ready}), 64'd3);
    chk("start_clears", 64'({word_count, err_fmt, err_full}), 64'd0);
  endtask

  task automatic end_check(input int wc, input logic ef, input logic efull);
    @(negedge clk);
    chk("end_done_busy_ready", 64'({done, busy, in_ready}), 64'b110);
    chk("end_word_count", 64'(word_count), 64'(wc));
    chk("end_errors", 64'({err_fmt, err_full}), 64'({ef, efull}));
    @(posedge clk); #1;
    chk("end_idle", 64'({busy, done}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_wc;
    logic exp_ef;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; base_addr = '0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    eptr = '0; eptr2 = '0;

    vt[0] = mk(2'b00, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 12'd0,   1'b0, 1'b1, 32'h002081B3);
    vt[1] = mk(2'b01, 7'h13, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 12'd42,  1'b0, 1'b1, 32'h02A00293);
    vt[2] = mk(2'b10, 7'h23, 5'd0,  5'd1,  5'd2,  3'd2, 7'h00, 12'd8,   1'b1, 1'b1, 32'h0020A423);
    vt[3] = mk(2'b00, 7'h33, 5'd10, 5'd11, 5'd12, 3'd0, 7'h20, 12'd0,   1'b0, 1'b1, 32'h40C58533);
    vt[4] = mk(2'b01, 7'h03, 5'd7,  5'd6,  5'd0,  3'd2, 7'h00, 12'hFFC, 1'b0, 1'b1, 32'hFFC32383);
    vt[5] = mk(2'b00, 7'h13, 5'd1,  5'd1,  5'd1,  3'd0, 7'h00, 12'd0,   1'b0, 1'b0, 32'h0);
    vt[6] = mk(2'b10, 7'h23, 5'd0,  5'd31, 5'd31, 3'd2, 7'h00, 12'hFFF, 1'b0, 1'b1, 32'hFFFFAFA3);
    vt[7] = mk(2'b11, 7'h33, 5'd1,  5'd2,  5'd3,  3'd0, 7'h00, 12'd0,   1'b0, 1'b0, 32'h0);
    vt[8] = mk(2'b10, 7'h03, 5'd1,  5'd2,  5'd3,  3'd2, 7'h00, 12'd4,   1'b0, 1'b0, 32'h0);
    vt[9] = mk(2'b01, 7'h33, 5'd1,  5'd2,  5'd3,  3'd0, 7'h00, 12'd1,   1'b1, 1'b0, 32'h0);

    // Reset mid-cycle, then valid held high in IDLE
    #1 reset = 1'b1;
    #2 chk("reset_outputs", 64'({in_ready, imem_we, imem_addr, imem_wdata, busy, done,
                                word_count, err_fmt, err_full}), 64'd0);
    @(negedge clk); reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_not_ready", 64'({in_ready, busy}), 64'd0);
    end
    in_valid = 1'b0;

    // Table: session at 0x10 (base case), then a session at 0xFE that wraps and mixes bad beats
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || vt[i-1].last) begin
        do_start(i == 0 ? 8'h10 : 8'hFE);
        exp_wc = 0; exp_ef = 1'b0;
      end
      send(vt[i], vt[i].last);
      if (vt[i].good) exp_wc++;
      else exp_ef = 1'b1;
      if (vt[i].last) end_check(exp_wc, exp_ef, 1'b0);
    end

    // Format error leaves the address unchanged
    do_start(8'h40);
    send(vt[5], 1'b0);
    @(negedge clk);
    chk("fmt_err_set", 64'({err_fmt, word_count}), 64'({1'b1, 9'd0}));
    @(posedge clk); #1;
    send(vt[0], 1'b1);
    end_check(1, 1'b1, 1'b0);

    // Valid gaps 1,0,0,1
    do_start(8'h50);
    send(vt[1], 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(vt[3], 1'b1);
    end_check(2, 1'b0, 1'b0);

    // Wrap and full on the AW=2 instance
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    en2 = 1'b1;
    do_start(8'h03);
    send(vt[0], 1'b0); send(vt[1], 1'b0); send(vt[3], 1'b0); send(vt[4], 1'b0);
    @(negedge clk);
    chk("full_done_busy_ready", 64'({done2, busy2, in_ready2}), 64'b110);
    chk("full_err_count", 64'({err_full2, err_fmt2, word_count2}), 64'({1'b1, 1'b0, 3'd4}));
    chk("wide_still_loading", 64'({busy, done, word_count}), 64'({1'b1, 1'b0, 9'd4}));
    @(posedge clk); #1;
    chk("full_back_idle", 64'(busy2), 64'd0);
    start = 1'b1; base_addr = 8'h00;
    @(posedge clk); #1;
    start = 1'b0; eptr2 = 2'd0;
    chk("restart_aw2", 64'({busy2, err_full2, word_count2}), 64'({1'b1, 1'b0, 3'd0}));
    chk("start_ignored_wide", 64'({busy, word_count}), 64'({1'b1, 9'd4}));
    send(vt[0], 1'b0); send(vt[1], 1'b0); send(vt[3], 1'b0); send(vt[4], 1'b1);
    @(negedge clk);
    chk("full_with_last", 64'({done2, err_full2, word_count2}), 64'({1'b1, 1'b0, 3'd4}));
    chk("wide_last_done", 64'({done, err_full, word_count}), 64'({1'b1, 1'b0, 9'd8}));
    @(posedge clk); #1;
    chk("both_idle", 64'({busy, busy2}), 64'd0);
    en2 = 1'b0;

    // Ignored start mid-LOAD, then reset right after an accept
    do_start(8'h20);
    send(vt[0], 1'b0);
    start = 1'b1; base_addr = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_start_ignored", 64'({busy, word_count}), 64'({1'b1, 9'd1}));
    send(vt[1], 1'b0);
    @(negedge clk);
    chk("count_after_two", 64'(word_count), 64'd2);
    @(posedge clk); #1;
    drive_fields(vt[3], 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    #1 chk("reset_mid_load", 64'({in_ready, imem_we, imem_addr, imem_wdata, busy, done,
                                 word_count, err_fmt, err_full}), 64'd0);
    @(negedge clk);
    chk("dropped_write", 64'({imem_we, busy}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'({busy, in_ready}), 64'd0);

    chk("pending_writes", 64'(q.size()), 64'd0);
    chk("pending_writes_aw2", 64'(q2.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
